// File: rtl/alu_uart_if.sv
// Byte-stream host interface for the ALU: collects A, B, OP (and SHAMT when
// ALU_IF_SHAMT_EN is defined) little-endian, runs one ALU op, then returns the result byte by byte.
module alu_uart_if #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_alu_data_A,
  output logic [NB_DATA-1:0] o_alu_data_B,
  output logic [4:0]         o_alu_shamt,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy
);
  localparam int NBYTES = NB_DATA / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, RX_SHAMT, EXEC, TX_LOAD, TX_WAIT} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, nidx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               started_q, started_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               rx_st, tmo, last_idx;
`ifdef ALU_IF_SHAMT_EN
  logic [4:0]         shamt_q, shamt_d;
`endif

  assign rx_st    = (state_q == RX_A) || (state_q == RX_B) ||
                    (state_q == RX_OP) || (state_q == RX_SHAMT);
  // Timeout only arms once a frame is partially received; it beats a same-cycle byte.
  assign tmo      = rx_st && started_q && (cnt_q == CW'(TIMEOUT_CYCLES));
  assign last_idx = (idx_q == IW'(NBYTES - 1));
  assign nidx     = idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    started_d = started_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    tx_data_d = tx_data_q;
`ifdef ALU_IF_SHAMT_EN
    shamt_d   = shamt_q;
`endif
    cnt_d     = (rx_st && started_q && !i_rx_valid) ? cnt_q + 1'b1 : '0;
    if (tmo) begin
      state_d   = RX_A;
      idx_d     = '0;
      started_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        RX_A: if (i_rx_valid) begin
          a_d[{idx_q, 3'b000} +: 8] = i_rx_data;
          started_d = 1'b1;
          idx_d     = last_idx ? '0 : nidx;
          if (last_idx) state_d = RX_B;
        end
        RX_B: if (i_rx_valid) begin
          b_d[{idx_q, 3'b000} +: 8] = i_rx_data;
          idx_d = last_idx ? '0 : nidx;
          if (last_idx) state_d = RX_OP;
        end
        RX_OP: if (i_rx_valid) begin
          op_d = i_rx_data[NB_OP-1:0];
`ifdef ALU_IF_SHAMT_EN
          state_d = RX_SHAMT;
`else
          started_d = 1'b0;
          state_d   = EXEC;
`endif
        end
`ifdef ALU_IF_SHAMT_EN
        RX_SHAMT: if (i_rx_valid) begin
          shamt_d   = i_rx_data[4:0];
          started_d = 1'b0;
          state_d   = EXEC;
        end
`endif
        EXEC: begin
          res_d     = i_alu_result;
          tx_data_d = i_alu_result[7:0];
          state_d   = TX_LOAD;
        end
        TX_LOAD: state_d = TX_WAIT;
        TX_WAIT: if (i_tx_done) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = RX_A;
          end else begin
            idx_d     = nidx;
            tx_data_d = 8'(res_q >> {nidx, 3'b000});
            state_d   = TX_LOAD;
          end
        end
        default: begin
          state_d = RX_A;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= RX_A;
      idx_q     <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '1;
      res_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      res_q     <= res_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef ALU_IF_SHAMT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) shamt_q <= '0;
    else          shamt_q <= shamt_d;
  end
  assign o_alu_shamt = shamt_q;
`else
  assign o_alu_shamt = 5'd0;
`endif

  assign o_alu_op     = op_q;
  assign o_alu_data_A = a_q;
  assign o_alu_data_B = b_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = (state_q == TX_LOAD);
  assign o_busy       = (state_q != RX_A);
endmodule
